// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller:
// FSM states, power-up init ROM, IO word bit positions and long-command opcodes.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int INIT_LEN   = 6;
  localparam int INIT_IDX_W = $clog2(INIT_LEN);

  // Entry 0 sits in the least significant byte, so index order equals send order.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  localparam int LCD_ON = 31;
  localparam int LCD_RS = 10;
  localparam int LCD_RW = 9;
  localparam int LCD_EN = 8;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  function automatic logic isLongCmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that stops at zero; o_zero marks the last cycle of a timed state.
module lcd_timer #(
  parameter int              W         = 8,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= RESET_VAL;
    end else if (i_load) begin
      cnt_q <= i_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD controller: autonomous power-up init, then one
// command/data byte per valid/ready handshake with setup, enable, hold and exec timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 4,
  parameter int T_PULSE   = 25,
  parameter int T_HOLD    = 4,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_req_rdy,
  input  logic        i_lcd_on,
  output logic        o_init_done,
  output logic        o_busy,
  output logic [31:0] o_io_lcd
);

  if ((T_POWERUP < 1) || (T_SETUP < 1) || (T_PULSE < 1) ||
      (T_HOLD < 1) || (T_EXEC < 1) || (T_CLEAR < 1)) begin : g_bad_timing
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  localparam int T_MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int T_MAX_B = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
  localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int TW      = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] LD_PWRUP = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_PULSE = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
  localparam logic [TW-1:0] LD_CLEAR = TW'(T_CLEAR - 1);

  localparam logic [INIT_IDX_W-1:0] LAST_IDX = INIT_IDX_W'(INIT_LEN - 1);
  localparam logic [INIT_IDX_W-1:0] IDX_ONE  = INIT_IDX_W'(1);

  lcd_state_e            state_q, state_d;
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
  logic                  rs_q, rs_d;
  logic [7:0]            data_q, data_d;
  logic                  done_q, done_d;
  logic                  en_q, rdy_q, busy_q, on_q;
  logic                  tmrLoad, tmrZero;
  logic [TW-1:0]         tmrVal;

  lcd_timer #(
    .W         (TW),
    .RESET_VAL (LD_PWRUP)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (tmrLoad),
    .i_val   (tmrVal),
    .o_zero  (tmrZero)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    tmrLoad = 1'b0;
    tmrVal  = '0;
    case (state_q)
      ST_PWRUP: if (tmrZero) state_d = ST_INIT;
      ST_IDLE: begin
        if (i_req_vld) begin
          state_d = ST_SETUP;
          rs_d    = i_req_rs;
          data_d  = i_req_data;
          tmrLoad = 1'b1;
          tmrVal  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmrZero) begin
          state_d = ST_PULSE;
          tmrLoad = 1'b1;
          tmrVal  = LD_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmrZero) begin
          state_d = ST_HOLD;
          tmrLoad = 1'b1;
          tmrVal  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmrZero) begin
          state_d = ST_WAIT;
          tmrLoad = 1'b1;
          tmrVal  = isLongCmd(rs_q, data_q) ? LD_CLEAR : LD_EXEC;
        end
      end
      ST_WAIT: begin
        if (tmrZero) begin
          if (done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_INIT;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    // INIT is resolved in the same cycle it is chosen, so the ROM byte's setup window starts at once.
    if (state_d == ST_INIT) begin
      state_d = ST_SETUP;
      rs_d    = 1'b0;
      data_d  = INIT_ROM[idx_d];
      tmrLoad = 1'b1;
      tmrVal  = LD_SETUP;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_PWRUP;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      en_q    <= (state_d == ST_PULSE);
      rdy_q   <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      on_q    <= i_lcd_on;
    end
  end

  always_comb begin
    o_io_lcd         = '0;
    o_io_lcd[LCD_ON] = on_q;
    o_io_lcd[LCD_RS] = rs_q;
    o_io_lcd[LCD_RW] = 1'b0;
    o_io_lcd[LCD_EN] = en_q;
    o_io_lcd[7:0]    = data_q;
  end

  assign o_req_rdy   = rdy_q;
  assign o_init_done = done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: randomized requests and lcd_on toggling checked every cycle
// against an edge-count timeline model of the init sequence and byte transfers.
module tb_lcd_ctrl;

  localparam int T_POWERUP   = 10;
  localparam int T_SETUP     = 2;
  localparam int T_PULSE     = 3;
  localparam int T_HOLD      = 2;
  localparam int T_EXEC      = 5;
  localparam int T_CLEAR     = 20;
  localparam int INIT_CYCLES = 97;

  logic        clk    = 1'b0;
  logic        rstN   = 1'b1;
  logic        vld    = 1'b0;
  logic        rsIn   = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic        lcdOn  = 1'b0;
  logic        rdy, initDone, busy;
  logic [31:0] ioLcd;

  lcd_ctrl #(
    .T_POWERUP (T_POWERUP),
    .T_SETUP   (T_SETUP),
    .T_PULSE   (T_PULSE),
    .T_HOLD    (T_HOLD),
    .T_EXEC    (T_EXEC),
    .T_CLEAR   (T_CLEAR)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rstN),
    .i_req_vld   (vld),
    .i_req_rs    (rsIn),
    .i_req_data  (dataIn),
    .o_req_rdy   (rdy),
    .i_lcd_on    (lcdOn),
    .o_init_done (initDone),
    .o_busy      (busy),
    .o_io_lcd    (ioLcd)
  );

  always #5 clk = ~clk;

  logic [7:0] initBytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  int checks = 0;
  int fails  = 0;

  int n, mIdx, mNext, mStart, mEnd, doneEdge, lastAccept;
  int enRiseEdge, enFallEdge, enPulses, dutRdyRise;
  bit mDone, mRdyPrev, acceptedNow, expEnNow, prevEn, prevRdy;
  logic       mRs, mOn;
  logic [7:0] mData;

  function automatic int byteCycles(input logic rs, input logic [7:0] d);
    bit longCmd;
    longCmd = !rs && (d >= 8'h01) && (d <= 8'h03);
    return T_SETUP + T_PULSE + T_HOLD + (longCmd ? T_CLEAR : T_EXEC);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s @edge %0d: observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rs, input logic [7:0] d);
    vld    = v;
    rsIn   = rs;
    dataIn = d;
  endtask

  task automatic maybeToggleOn();
    if ($urandom_range(0, 5) == 0) lcdOn = ~lcdOn;
  endtask

  task automatic modelReset();
    n          = 0;
    mIdx       = 0;
    mNext      = T_POWERUP;
    mStart     = -1000;
    mEnd       = 0;
    mDone      = 1'b0;
    mRdyPrev   = 1'b0;
    mRs        = 1'b0;
    mData      = 8'h00;
    doneEdge   = -1;
    lastAccept = -1;
    enRiseEdge = -1;
    enFallEdge = -1;
    dutRdyRise = -1;
    enPulses   = 0;
    prevEn     = 1'b0;
    prevRdy    = 1'b0;
  endtask

  task automatic startByte(input logic rs, input logic [7:0] d);
    mStart = n;
    mRs    = rs;
    mData  = d;
    mEnd   = n + byteCycles(rs, d);
  endtask

  // Advance one clock edge, update the timeline model, then compare every output at the negedge.
  task automatic step();
    bit expRdy;
    logic [31:0] expWord;
    @(posedge clk);
    n++;
    acceptedNow = 1'b0;
    mOn = lcdOn;
    if (!mDone) begin
      if (n == mNext) begin
        if (mIdx == 6) begin
          mDone    = 1'b1;
          doneEdge = n;
        end else begin
          startByte(1'b0, initBytes[mIdx]);
          mNext = mEnd;
          mIdx++;
        end
      end
    end else if (vld && mRdyPrev) begin
      startByte(rsIn, dataIn);
      acceptedNow = 1'b1;
      lastAccept  = n;
    end
    @(negedge clk);
    expRdy   = mDone && (n >= mEnd);
    expEnNow = (n >= mStart + T_SETUP) && (n < mStart + T_SETUP + T_PULSE);
    expWord  = {mOn, 20'd0, mRs, 1'b0, expEnNow, mData};
    checkOutput("io_lcd", ioLcd, expWord);
    checkOutput("req_rdy", 32'(rdy), 32'(expRdy));
    checkOutput("busy", 32'(busy), 32'(!expRdy));
    checkOutput("init_done", 32'(initDone), 32'(mDone));
    if (ioLcd[8] && !prevEn) begin
      enPulses++;
      enRiseEdge = n;
    end
    if (!ioLcd[8] && prevEn) enFallEdge = n;
    if (rdy && !prevRdy) dutRdyRise = n;
    prevEn   = ioLcd[8];
    prevRdy  = rdy;
    mRdyPrev = expRdy;
  endtask

  task automatic runInit(input string tag);
    for (int i = 0; i < 105; i++) begin
      if (n < 85) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      else applyStimulus(1'b0, 1'b0, 8'h00);
      maybeToggleOn();
      step();
    end
    checkOutput({tag, "_done_edge"}, 32'(doneEdge), 32'(INIT_CYCLES));
    checkOutput({tag, "_en_pulses"}, 32'(enPulses), 32'd6);
  endtask

  task automatic waitAccept(input string tag);
    int budget;
    budget = 0;
    do begin
      maybeToggleOn();
      step();
      budget++;
    end while (!acceptedNow && budget < 200);
    checkOutput({tag, "_accepted"}, 32'(acceptedNow), 32'd1);
  endtask

  task automatic sendByte(input string tag, input logic rs, input logic [7:0] d, input int expGap);
    int acc, budget;
    applyStimulus(1'b1, rs, d);
    waitAccept(tag);
    acc = lastAccept;
    applyStimulus(1'b0, rs, d);
    budget = 0;
    do begin
      maybeToggleOn();
      step();
      budget++;
    end while (!rdy && budget < 200);
    checkOutput({tag, "_en_start"}, 32'(enRiseEdge - acc), 32'(T_SETUP));
    checkOutput({tag, "_en_width"}, 32'(enFallEdge - enRiseEdge), 32'(T_PULSE));
    checkOutput({tag, "_rdy_gap"}, 32'(dutRdyRise - acc), 32'(expGap));
  endtask

  initial begin
    int firstAcc, secondAcc, budget;
    modelReset();
    lcdOn = 1'b1;
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_io_lcd", ioLcd, 32'd0);
    checkOutput("reset_rdy", 32'(rdy), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(initDone), 32'd0);
    rstN = 1'b1;
    modelReset();
    runInit("init");

    sendByte("data41", 1'b1, 8'h41, 12);
    sendByte("clear01", 1'b0, 8'h01, 27);
    sendByte("data01", 1'b1, 8'h01, 12);

    applyStimulus(1'b1, 1'b1, 8'h48);
    waitAccept("held48");
    firstAcc = lastAccept;
    applyStimulus(1'b1, 1'b1, 8'h49);
    waitAccept("held49");
    secondAcc = lastAccept;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("held_accept_gap", 32'(secondAcc - firstAcc), 32'd13);
    checkOutput("held_rdy_cycle", 32'(dutRdyRise), 32'(secondAcc - 1));

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(1'b1, 1'b0, 8'($urandom_range(1, 3)));
        1: applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        default: applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      endcase
      maybeToggleOn();
      step();
    end

    applyStimulus(1'b1, 1'b0, 8'h38);
    waitAccept("rst_mid");
    applyStimulus(1'b0, 1'b0, 8'h00);
    budget = 0;
    while (!expEnNow && budget < 50) begin
      step();
      budget++;
    end
    checkOutput("rst_mid_en_before", 32'(ioLcd[8]), 32'd1);
    #3 rstN = 1'b0;
    #1;
    checkOutput("rst_mid_io_lcd", ioLcd, 32'd0);
    checkOutput("rst_mid_rdy", 32'(rdy), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_done", 32'(initDone), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
    runInit("reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
